// File: rtl/seq_multiplier.sv
// Sequential unsigned shift-add multiplier for the RISC SPM datapath.
//
// Ports:
//   clk      - clock, rising edge
//   rst      - asynchronous active-low reset
//   load_md  - start strobe (control unit Load_Reg_md); may be held high
//   op_a     - multiplicand (Reg_Y)
//   op_b     - multiplier (Bus_1)
//   mul_done - product valid; high for the single DONE cycle
//   mul_busy - high while iterating
//   mul_lsb  - product[word_size-1:0]
//   mul_msb  - product[2*word_size-1:word_size]
//   mul_zero - final product == 0 (valid while mul_done)
//   mul_ovf  - final product does not fit in one word (valid while mul_done)
//
// Build option: define MUL_EARLY_EXIT_EN to finish as soon as the remaining
// multiplier bits are all zero (minimum one iteration, same product).
module seq_multiplier #(
    parameter int unsigned word_size = 8,
    parameter int unsigned cnt_size  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_md,
    input  logic [word_size-1:0] op_a,
    input  logic [word_size-1:0] op_b,
    output logic                 mul_done,
    output logic                 mul_busy,
    output logic [word_size-1:0] mul_lsb,
    output logic [word_size-1:0] mul_msb,
    output logic                 mul_zero,
    output logic                 mul_ovf
);

    localparam int unsigned PW = 2 * word_size;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]           state_q,  state_d;
    logic [PW-1:0]        prod_q,   prod_d;
    logic [PW-1:0]        mcand_q,  mcand_d;
    logic [word_size-1:0] mplier_q, mplier_d;
    logic [cnt_size-1:0]  cnt_q,    cnt_d;
    logic                 done_q,   done_d;
    logic                 busy_q,   busy_d;
    logic                 zero_q,   zero_d;
    logic                 ovf_q,    ovf_d;
    logic                 last_iter;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            prod_q   <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            prod_q   <= prod_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
        end
    end

    // Next-state, datapath and registered-output logic
    always_comb begin
        state_d   = state_q;
        prod_d    = prod_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        busy_d    = busy_q;
        zero_d    = 1'b0;
        ovf_d     = 1'b0;
        last_iter = 1'b0;

        case (state_q)
            IDLE: begin
                if (load_md) begin
                    mcand_d  = PW'(op_a);
                    mplier_d = op_b;
                    prod_d   = '0;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = BUSY;
                end
            end

            BUSY: begin
                if (mplier_q[0]) begin
                    prod_d = prod_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + cnt_size'(1);
`ifdef MUL_EARLY_EXIT_EN
                // No set bits left to add: the product is already final
                last_iter = (cnt_d == cnt_size'(word_size)) || (mplier_d == '0);
`else
                last_iter = (cnt_d == cnt_size'(word_size));
`endif
                if (last_iter) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    zero_d  = (prod_d == '0);
                    ovf_d   = (prod_d[PW-1:word_size] != '0);
                end
            end

            DONE: begin
                // A strobe seen in DONE is a fresh start
                if (load_md) begin
                    mcand_d  = PW'(op_a);
                    mplier_d = op_b;
                    prod_d   = '0;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = BUSY;
                end else begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign mul_done = done_q;
    assign mul_busy = busy_q;
    assign mul_lsb  = prod_q[word_size-1:0];
    assign mul_msb  = prod_q[PW-1:word_size];
    assign mul_zero = zero_q;
    assign mul_ovf  = ovf_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier: stimulus pushes expected results,
// a negedge monitor pops and checks on each rising mul_done.
module tb_seq_multiplier;

    logic       clk = 1'b0;
    logic       rst;
    logic       load_md;
    logic [7:0] op_a, op_b;
    logic       mul_done, mul_busy, mul_zero, mul_ovf;
    logic [7:0] mul_lsb, mul_msb;

    typedef struct {
        logic [7:0] lsb;
        logic [7:0] msb;
        logic       zero;
        logic       ovf;
        int         done_cyc;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    logic done_prev = 1'b0;

    seq_multiplier #(.word_size(8), .cnt_size(4)) dut (
        .clk(clk), .rst(rst), .load_md(load_md), .op_a(op_a), .op_b(op_b),
        .mul_done(mul_done), .mul_busy(mul_busy), .mul_lsb(mul_lsb),
        .mul_msb(mul_msb), .mul_zero(mul_zero), .mul_ovf(mul_ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected iteration count for a given multiplier
    function automatic int exp_lat(input logic [7:0] b);
`ifdef MUL_EARLY_EXIT_EN
        int hb;
        hb = 0;
        for (int i = 0; i < 8; i++) if (b[i]) hb = i;
        return hb + 1;
`else
        return (b == b) ? 8 : 8;
`endif
    endfunction

    function automatic exp_t mk(input logic [15:0] p, input int cap, input logic [7:0] b);
        exp_t e;
        e.lsb      = p[7:0];
        e.msb      = p[15:8];
        e.zero     = (p == 16'h0);
        e.ovf      = (p[15:8] != 8'h0);
        e.done_cyc = cap + exp_lat(b);
        return e;
    endfunction

    // Monitor: check each completion against the scoreboard head
    always @(negedge clk) begin
        done_prev <= mul_done;
        if (rst && mul_done && !done_prev) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 32'(mul_done), 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("lsb",     32'(mul_lsb),  32'(e.lsb));
                chk("msb",     32'(mul_msb),  32'(e.msb));
                chk("zero",    32'(mul_zero), 32'(e.zero));
                chk("ovf",     32'(mul_ovf),  32'(e.ovf));
                chk("latency", 32'(cyc),      32'(e.done_cyc));
                chk("busy_at_done", 32'(mul_busy), 32'd0);
            end
        end
    end

    // One-cycle start strobe; push expected product
    task automatic start(input logic [7:0] a, input logic [7:0] b, input logic [15:0] p);
        @(negedge clk);
        op_a = a; op_b = b; load_md = 1'b1;
        q.push_back(mk(p, cyc + 1, b));
        @(posedge clk);
        #1 load_md = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        chk("drain_timeout", 32'(q.size()), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_done"}, 32'(mul_done), 32'd0);
        chk({tag, "_busy"}, 32'(mul_busy), 32'd0);
        chk({tag, "_lsb"},  32'(mul_lsb),  32'd0);
        chk({tag, "_msb"},  32'(mul_msb),  32'd0);
        chk({tag, "_zero"}, 32'(mul_zero), 32'd0);
        chk({tag, "_ovf"},  32'(mul_ovf),  32'd0);
    endtask

    initial begin
        rst = 1'b0; load_md = 1'b0; op_a = 8'h0; op_b = 8'h0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b1;

        // Abort FF x FF after three iterations
        @(negedge clk);
        op_a = 8'hFF; op_b = 8'hFF; load_md = 1'b1;
        @(posedge clk);
        #1 load_md = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("busy_before_abort", 32'(mul_busy), 32'd1);
        #2 rst = 1'b0;
        #1 chk_all_zero("abort");
        repeat (12) @(negedge clk);
        chk("abort_no_done", 32'(mul_done), 32'd0);
        rst = 1'b1;
        start(8'd2, 8'd3, 16'h0006);
        drain();

        // Basic product
        start(8'd13, 8'd11, 16'h008F);
        repeat (3) @(negedge clk);
        chk("busy_mid", 32'(mul_busy), 32'd1);
        drain();

        // Strobe held 9 cycles, operand change during BUSY ignored
        @(negedge clk);
        op_a = 8'hFF; op_b = 8'hFF; load_md = 1'b1;
        q.push_back(mk(16'hFE01, cyc + 1, 8'hFF));
        @(posedge clk);
        #1 op_b = 8'h00;
        repeat (8) @(posedge clk);
        #1 load_md = 1'b0;
        drain();
        repeat (12) @(negedge clk);
        chk("held_idle_busy", 32'(mul_busy), 32'd0);
        chk("held_lsb_persist", 32'(mul_lsb), 32'h01);
        chk("held_msb_persist", 32'(mul_msb), 32'hFE);

        // Zero operand
        start(8'h00, 8'h5A, 16'h0000);
        drain();

        // Back-to-back restart from DONE
        start(8'd4, 8'd4, 16'h0010);
        begin
            int n;
            n = 0;
            while (!mul_done && n < 40) begin @(negedge clk); n++; end
            chk("b2b_wait_done", 32'(mul_done), 32'd1);
        end
        op_a = 8'd7; op_b = 8'd9; load_md = 1'b1;
        q.push_back(mk(16'h003F, cyc + 1, 8'd9));
        @(posedge clk);
        #1 load_md = 1'b0;
        chk("b2b_done_drop", 32'(mul_done), 32'd0);
        chk("b2b_busy", 32'(mul_busy), 32'd1);
        drain();
        // load_md low in DONE: back to IDLE, product held
        repeat (5) @(negedge clk);
        chk("idle_done_clr", 32'(mul_done), 32'd0);
        chk("idle_lsb_hold", 32'(mul_lsb), 32'h3F);
        chk("idle_msb_hold", 32'(mul_msb), 32'h00);

        // Early-exit vectors (same products in either build)
        start(8'd5, 8'd3, 16'h000F);
        drain();
        start(8'd5, 8'h80, 16'h0280);
        drain();
        start(8'hFF, 8'h01, 16'h00FF);
        drain();

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got t=%0t expected completion", $time);
        $fatal(1, "timeout");
    end

endmodule
